// File: rtl/photo_sensor_conditioner.sv
// Photocell front-end: per-channel synchroniser, debounce and rising-edge event pulse.
// Channel 0 is the back cell (enter), channel 1 is the front cell (leave).
// Optional blocked-beam watchdog is built when PHOTO_STUCK_DETECT_EN is defined;
// otherwise the stuck output is tied low.
module photo_sensor_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic back_raw,
  input  logic front_raw,
  output logic backphoto,
  output logic forwardphoto,
  output logic back_level,
  output logic front_level,
  output logic stuck
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_pulse;
  logic [1:0] w_stuck_hit;

  assign w_raw = {front_raw, back_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DbW-1:0]         r_cnt;
    logic [DbW-1:0]         w_cnt_d;
    logic                   r_stable;
    logic                   w_stable_d;
    logic                   r_pulse;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Shift the raw level through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
      end
    end

    // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles
    always_comb begin
      w_cnt_d    = r_cnt;
      w_stable_d = r_stable;
      if (w_synced == r_stable) begin
        w_cnt_d = '0;
      end else if (r_cnt == DbLast) begin
        w_stable_d = w_synced;
        w_cnt_d    = '0;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end

    // Register debounce state; pulse rises on the same edge as the level so they coincide
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
        r_pulse  <= 1'b0;
      end else begin
        r_cnt    <= w_cnt_d;
        r_stable <= w_stable_d;
        r_pulse  <= w_stable_d & ~r_stable;
      end
    end

    assign w_level[g] = r_stable;
    assign w_pulse[g] = r_pulse;

`ifdef PHOTO_STUCK_DETECT_EN
    localparam int unsigned StW = $clog2(STUCK_CYCLES + 1);
    localparam logic [StW-1:0] StMax = StW'(STUCK_CYCLES);

    logic [StW-1:0] r_stk;
    logic [StW-1:0] w_stk_d;

    // Count blocked cycles, saturating; any clear level restarts the count
    always_comb begin
      w_stk_d = r_stk;
      if (!r_stable) begin
        w_stk_d = '0;
      end else if (r_stk != StMax) begin
        w_stk_d = r_stk + 1'b1;
      end
    end

    // Hold the blocked-cycle count
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_stk <= '0;
      end else begin
        r_stk <= w_stk_d;
      end
    end

    assign w_stuck_hit[g] = (w_stk_d == StMax);
`else
    assign w_stuck_hit[g] = 1'b0;
`endif
  end

`ifdef PHOTO_STUCK_DETECT_EN
  logic r_stuck;

  // Flag a beam that has stayed blocked for the full watchdog window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stuck <= 1'b0;
    end else begin
      r_stuck <= |w_stuck_hit;
    end
  end

  assign stuck = r_stuck;
`else
  // Watchdog absent: the AND keeps the parameter referenced while the output stays 0
  assign stuck = (|w_stuck_hit) & (STUCK_CYCLES == 0);
`endif

  assign backphoto    = w_pulse[0];
  assign forwardphoto = w_pulse[1];
  assign back_level   = w_level[0];
  assign front_level  = w_level[1];

endmodule

// File: tb/tb_photo_sensor_conditioner.sv
// Directed bench for photo_sensor_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STUCK_CYCLES=20).
// Cycle indices below count rising edges after the input change, the first sampling edge being 1.
module tb_photo_sensor_conditioner;

  logic clk = 1'b0;
  logic reset_n;
  logic back_raw;
  logic front_raw;
  logic backphoto;
  logic forwardphoto;
  logic back_level;
  logic front_level;
  logic stuck;

  int checks   = 0;
  int failures = 0;
  int stuck_hi = 0;

  photo_sensor_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .back_raw    (back_raw),
    .front_raw   (front_raw),
    .backphoto   (backphoto),
    .forwardphoto(forwardphoto),
    .back_level  (back_level),
    .front_level (front_level),
    .stuck       (stuck)
  );

  always #5 clk = ~clk;

  // Advance n cycles, sampling 1 time unit after each rising edge
  task automatic run_cycles(input int n, output int nb, output int nf,
                            output int fb, output int ff,
                            output int bl1, output int bl0,
                            output int fl1, output int fl0);
    nb = 0; nf = 0; fb = 0; ff = 0; bl1 = 0; bl0 = 0; fl1 = 0; fl0 = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (backphoto)    begin nb++; if (fb == 0) fb = i; end
      if (forwardphoto) begin nf++; if (ff == 0) ff = i; end
      if (back_level   && bl1 == 0) bl1 = i;
      if (!back_level  && bl0 == 0) bl0 = i;
      if (front_level  && fl1 == 0) fl1 = i;
      if (!front_level && fl0 == 0) fl0 = i;
      if (stuck) stuck_hi++;
    end
  endtask

  task automatic test_reset();
    int nb, nf, fb, ff, bl1, bl0, fl1, fl0;
    reset_n = 1'b0; back_raw = 1'b1; front_raw = 1'b1;
    #1;
    checks++;
    if ({backphoto, forwardphoto, back_level, front_level, stuck} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=00000",
               {backphoto, forwardphoto, back_level, front_level, stuck});
    end
    run_cycles(5, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (nb + nf !== 0 || bl1 !== 0 || fl1 !== 0) begin
      failures++;
      $display("FAIL reset_hold pulses=%0d bl1=%0d fl1=%0d want 0 0 0", nb + nf, bl1, fl1);
    end
    reset_n = 1'b1;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (nb !== 1 || fb !== 6) begin
      failures++;
      $display("FAIL release_back count=%0d at=%0d want 1 at 6", nb, fb);
    end
    checks++;
    if (nf !== 1 || ff !== 6) begin
      failures++;
      $display("FAIL release_front count=%0d at=%0d want 1 at 6", nf, ff);
    end
    back_raw = 1'b0; front_raw = 1'b0;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (back_level !== 1'b0 || front_level !== 1'b0 || nb + nf !== 0) begin
      failures++;
      $display("FAIL release_clear levels=%b%b pulses=%0d want 00 0",
               back_level, front_level, nb + nf);
    end
  endtask

  task automatic test_clean_entry();
    int nb, nf, fb, ff, bl1, bl0, fl1, fl0;
    back_raw = 1'b1;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (nb !== 1 || fb !== 6) begin
      failures++;
      $display("FAIL entry_pulse count=%0d at=%0d want 1 at 6", nb, fb);
    end
    checks++;
    if (bl1 !== 6 || back_level !== 1'b1 || nf !== 0) begin
      failures++;
      $display("FAIL entry_level rise=%0d end=%b fwd=%0d want 6 1 0", bl1, back_level, nf);
    end
    back_raw = 1'b0;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (bl0 !== 6 || nb !== 0) begin
      failures++;
      $display("FAIL entry_clear fall=%0d pulses=%0d want 6 0", bl0, nb);
    end
  endtask

  task automatic test_glitch();
    int nb, nf, fb, ff, bl1, bl0, fl1, fl0;
    int tot;
    front_raw = 1'b1;
    run_cycles(3, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    tot = nf;
    front_raw = 1'b0;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    tot += nf;
    checks++;
    if (tot !== 0 || fl1 !== 0 || front_level !== 1'b0) begin
      failures++;
      $display("FAIL glitch3 pulses=%0d rise=%0d level=%b want 0 0 0", tot, fl1, front_level);
    end
    front_raw = 1'b1;
    run_cycles(4, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    tot = nf;
    front_raw = 1'b0;
    run_cycles(12, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    tot += nf;
    checks++;
    if (tot !== 1 || ff !== 2) begin
      failures++;
      $display("FAIL glitch4 pulses=%0d at=%0d want 1 at 2", tot, ff);
    end
    checks++;
    if (front_level !== 1'b0 || nb !== 0) begin
      failures++;
      $display("FAIL glitch4_clear level=%b back=%0d want 0 0", front_level, nb);
    end
  endtask

  task automatic test_simultaneous();
    int nb, nf, fb, ff, bl1, bl0, fl1, fl0;
    back_raw = 1'b1; front_raw = 1'b1;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (nb !== 1 || nf !== 1 || fb !== 6 || ff !== 6) begin
      failures++;
      $display("FAIL simultaneous back=%0d@%0d front=%0d@%0d want 1@6 1@6", nb, fb, nf, ff);
    end
    back_raw = 1'b0; front_raw = 1'b0;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (nb + nf !== 0 || bl0 !== 6 || fl0 !== 6) begin
      failures++;
      $display("FAIL simultaneous_clear pulses=%0d falls=%0d,%0d want 0 6,6", nb + nf, bl0, fl0);
    end
  endtask

  task automatic test_chatter();
    int nb, nf, fb, ff, bl1, bl0, fl1, fl0;
    int tot;
    back_raw = 1'b1;
    run_cycles(1, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    tot = nb;
    back_raw = 1'b0;
    run_cycles(1, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    tot += nb;
    back_raw = 1'b1;
    run_cycles(12, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    tot += nb;
    checks++;
    if (tot !== 1 || fb !== 6) begin
      failures++;
      $display("FAIL chatter pulses=%0d at=%0d want 1 at 6", tot, fb);
    end
    back_raw = 1'b0;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
  endtask

  task automatic test_reset_mid_count();
    int nb, nf, fb, ff, bl1, bl0, fl1, fl0;
    back_raw = 1'b1;
    run_cycles(4, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (back_level !== 1'b0 || backphoto !== 1'b0 || nb !== 0) begin
      failures++;
      $display("FAIL midreset_immediate level=%b pulse=%b early=%0d want 0 0 0",
               back_level, backphoto, nb);
    end
    run_cycles(3, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (nb !== 0 || bl1 !== 0) begin
      failures++;
      $display("FAIL midreset_hold pulses=%0d rise=%0d want 0 0", nb, bl1);
    end
    reset_n = 1'b1;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
    checks++;
    if (nb !== 1 || fb !== 6) begin
      failures++;
      $display("FAIL midreset_restart count=%0d at=%0d want 1 at 6", nb, fb);
    end
    back_raw = 1'b0;
    run_cycles(10, nb, nf, fb, ff, bl1, bl0, fl1, fl0);
  endtask

`ifdef PHOTO_STUCK_DETECT_EN
  task automatic test_stuck();
    int rise, st, fall, st0;
    rise = 0; st = 0; fall = 0; st0 = 0;
    back_raw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (back_level && rise == 0) rise = i;
      if (stuck && st == 0) st = i;
    end
    checks++;
    if (rise !== 6 || st !== 26) begin
      failures++;
      $display("FAIL stuck_rise level=%0d stuck=%0d want 6 26", rise, st);
    end
    back_raw = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (!back_level && fall == 0) fall = i;
      if (!stuck && st0 == 0) st0 = i;
    end
    checks++;
    if (fall !== 6 || st0 !== 7) begin
      failures++;
      $display("FAIL stuck_fall level=%0d stuck=%0d want 6 7", fall, st0);
    end
  endtask
`else
  task automatic test_stuck();
    checks++;
    if (stuck_hi !== 0 || stuck !== 1'b0) begin
      failures++;
      $display("FAIL stuck_off high_cycles=%0d now=%b want 0 0", stuck_hi, stuck);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; back_raw = 1'b0; front_raw = 1'b0;
    test_reset();
    test_clean_entry();
    test_glitch();
    test_simultaneous();
    test_chatter();
    test_reset_mid_count();
    test_stuck();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
